// File: rtl/bus_decoder_fsm.sv
// N-channel base/mask address decoder with a single outstanding request, registered response and error counter.
// Optional slave timeout is built when BUS_DECODER_TIMEOUT_EN is defined.
module bus_decoder_fsm #(
  parameter int                     N_SLAVES = 4,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE = {32'h80003000, 32'h80001000, 32'h80000800, 32'h00000000},
  parameter logic [N_SLAVES*32-1:0] SLV_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFFF00},
  parameter int                     TIMEOUT  = 16,
  parameter int                     ERRCNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [31:0]              addr_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [ERRCNT_W-1:0]      err_cnt_o,
  output logic [N_SLAVES-1:0]      slv_req_o,
  output logic                     slv_we_o,
  output logic [31:0]              slv_addr_o,
  input  logic [N_SLAVES-1:0]      slv_rvalid_i,
  input  logic [N_SLAVES*32-1:0]   slv_rdata_i
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [N_SLAVES-1:0] hit;
  logic [31:0]         slv_rdata_arr [N_SLAVES];
  logic                hit_any;
  logic [SEL_W-1:0]    hit_idx;
  logic                timeout_hit;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_chan
    assign hit[gi]           = ((addr_i & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32]);
    assign slv_rdata_arr[gi] = slv_rdata_i[gi*32 +: 32];
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any = 1'b1;
        hit_idx = k[SEL_W-1:0];
      end
    end
  end

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // WAIT lasts at most TIMEOUT-1 cycles, so the error response lands TIMEOUT cycles after the request.
  assign timeout_hit = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT - 2));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout;

  // TIMEOUT only matters when the timeout counter is built.
  assign unused_timeout = (TIMEOUT < 2);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_o     = 1'b0;
    slv_req_o = '0;
    case (state_q)
      ST_IDLE: begin
        gnt_o = 1'b1;
        if (req_i) begin
          if (hit_any) begin
            slv_req_o[hit_idx] = 1'b1;
            sel_d              = hit_idx;
            state_d            = ST_WAIT;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (slv_rvalid_i[sel_q]) begin
          rdata_d = slv_rdata_arr[sel_q];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rdata_d = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rvalid_o   = (state_q == ST_RESP);
  assign err_o      = rvalid_o & err_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_cnt_o  = err_cnt_q;
  assign slv_we_o   = we_i & (|slv_req_o);
  assign slv_addr_o = addr_i;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rvalid_o && err_o && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_decoder_fsm.sv
// Randomized transaction-level bench for bus_decoder_fsm against a window-decode reference model.
module tb_bus_decoder_fsm;

  localparam int           N_SLAVES = 4;
  localparam logic [127:0] SLV_BASE = {32'h80003000, 32'h80001000, 32'h80000800, 32'h00000000};
  localparam logic [127:0] SLV_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFFF00};
  localparam int           TIMEOUT  = 16;
  localparam int           ERRCNT_W = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [31:0]   addr_i = '0;
  logic          gnt_o, rvalid_o, err_o, busy_o, slv_we_o;
  logic [31:0]   rdata_o, slv_addr_o;
  logic [7:0]    err_cnt_o;
  logic [3:0]    slv_req_o;
  logic [3:0]    slv_rvalid_i = '0;
  logic [127:0]  slv_rdata_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  int          model_errcnt = 0;
  logic [31:0] model_rdata = '0;

  bus_decoder_fsm #(
    .N_SLAVES(N_SLAVES), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK),
    .TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o), .slv_req_o(slv_req_o),
    .slv_we_o(slv_we_o), .slv_addr_o(slv_addr_o),
    .slv_rvalid_i(slv_rvalid_i), .slv_rdata_i(slv_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lowest-index window whose masked base matches, or -1 when unmapped.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < N_SLAVES; k++) begin
      if ((a & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int ch);
    logic [3:0] v;
    v = '0;
    if (ch >= 0) v[ch] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void count_error();
    if (model_errcnt < 255) model_errcnt++;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".gnt"}, gnt_o, 1'b1);
    check_eq({tag, ".rvalid"}, rvalid_o, 1'b0);
    check_eq({tag, ".err"}, err_o, 1'b0);
    check_eq({tag, ".busy"}, busy_o, 1'b0);
    check_eq({tag, ".rdata_hold"}, rdata_o, model_rdata);
    check_eq({tag, ".err_cnt"}, err_cnt_o, model_errcnt[7:0]);
  endtask

  // Idle cycle with stray slave strobes that must be ignored.
  task automatic idle_cycle();
    next_cycle();
    req_i        = 1'b0;
    addr_i       = $urandom;
    slv_rvalid_i = 4'($urandom);
    slv_rdata_i  = rand_wide();
    @(negedge clk_i);
    check_idle("idle");
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input int delay,
                         input logic [31:0] data, input bit distract);
    int         ch;
    logic [3:0] oh;
    ch = decode(addr);
    oh = onehot(ch);
    next_cycle();
    req_i        = 1'b1;
    we_i         = we;
    addr_i       = addr;
    // A strobe from the target in the request cycle is too early and must be dropped.
    slv_rvalid_i = ($urandom_range(0, 1) == 1) ? oh : 4'b0000;
    slv_rdata_i  = rand_wide();
    @(negedge clk_i);
    check_idle("req");
    check_eq("req.slv_req", slv_req_o, oh);
    check_eq("req.slv_we", slv_we_o, (ch >= 0) && we);
    check_eq("req.slv_addr", slv_addr_o, addr);
    if (ch >= 0) begin
      for (int i = 1; i <= delay; i++) begin
        next_cycle();
        req_i        = $urandom_range(0, 1) == 1;
        we_i         = $urandom_range(0, 1) == 1;
        addr_i       = (i % 2 == 1) ? addr : $urandom;
        slv_rdata_i  = rand_wide();
        slv_rvalid_i = distract ? (4'($urandom) & ~oh) : 4'b0000;
        if (i == delay) begin
          slv_rvalid_i[ch]         = 1'b1;
          slv_rdata_i[ch*32 +: 32] = data;
        end
        @(negedge clk_i);
        check_eq("wait.rvalid", rvalid_o, 1'b0);
        check_eq("wait.gnt", gnt_o, 1'b0);
        check_eq("wait.busy", busy_o, 1'b1);
        check_eq("wait.slv_req", slv_req_o, 4'b0000);
        check_eq("wait.slv_we", slv_we_o, 1'b0);
      end
      model_rdata = data;
    end else begin
      model_rdata = '0;
      count_error();
    end
    next_cycle();
    req_i        = 1'b0;
    we_i         = 1'b0;
    slv_rvalid_i = '0;
    @(negedge clk_i);
    check_eq("resp.rvalid", rvalid_o, 1'b1);
    check_eq("resp.err", err_o, ch < 0);
    check_eq("resp.rdata", rdata_o, model_rdata);
    check_eq("resp.gnt", gnt_o, 1'b0);
    check_eq("resp.busy", busy_o, 1'b1);
    $display("txn addr=%08h we=%0d ch=%0d delay=%0d rdata=%08h err=%0d", addr, we, ch, delay, rdata_o, err_o);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".gnt"}, gnt_o, 1'b1);
    check_eq({tag, ".rvalid"}, rvalid_o, 1'b0);
    check_eq({tag, ".err"}, err_o, 1'b0);
    check_eq({tag, ".rdata"}, rdata_o, 32'h0);
    check_eq({tag, ".busy"}, busy_o, 1'b0);
    check_eq({tag, ".err_cnt"}, err_cnt_o, 8'h0);
    check_eq({tag, ".slv_req"}, slv_req_o, 4'b0000);
    check_eq({tag, ".slv_we"}, slv_we_o, 1'b0);
  endtask

  task automatic random_addr(output logic [31:0] a);
    int k;
    k = $urandom_range(0, 4);
    if (k == 4) a = $urandom;
    else a = SLV_BASE[k*32 +: 32] | ($urandom & ~SLV_MASK[k*32 +: 32]);
  endtask

  initial begin
    logic [31:0] a;
    #1 rst_i = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    run_txn(32'h00000010, 1'b0, 1, 32'h12345678, 1'b0);
    run_txn(32'h80000802, 1'b1, 3, $urandom, 1'b0);
    run_txn(32'h80002000, 1'b0, 1, 32'h0, 1'b0);
    idle_cycle();
    run_txn(32'h80001004, 1'b0, 4, 32'h0000000F, 1'b1);
    idle_cycle();

`ifdef BUS_DECODER_TIMEOUT_EN
    // Response on the last permitted WAIT cycle still wins over the timeout.
    run_txn(32'h80003004, 1'b0, TIMEOUT - 1, 32'h0BADF00D, 1'b1);
    next_cycle();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h80003000; slv_rvalid_i = '0;
    @(negedge clk_i);
    check_eq("tmo.slv_req", slv_req_o, 4'b1000);
    for (int i = 1; i < TIMEOUT; i++) begin
      next_cycle();
      req_i = 1'b0; slv_rvalid_i = 4'b0111;
      @(negedge clk_i);
      check_eq("tmo.wait_rvalid", rvalid_o, 1'b0);
    end
    next_cycle();
    slv_rvalid_i = '0;
    @(negedge clk_i);
    model_rdata = 32'hDEADBEEF;
    count_error();
    check_eq("tmo.rvalid", rvalid_o, 1'b1);
    check_eq("tmo.err", err_o, 1'b1);
    check_eq("tmo.rdata", rdata_o, 32'hDEADBEEF);
    next_cycle();
    slv_rvalid_i = 4'b1000;
    slv_rdata_i[127:96] = 32'h55555555;
    @(negedge clk_i);
    check_idle("tmo.after");
    idle_cycle();
`endif

    for (int t = 0; t < 150; t++) begin
      random_addr(a);
      run_txn(a, $urandom_range(0, 1) == 1, $urandom_range(1, 6), $urandom, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Mid-transaction reset, then a late response from the abandoned slave.
    next_cycle();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h80003008; slv_rvalid_i = '0;
    next_cycle();
    req_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst.pre_busy", busy_o, 1'b1);
    #2 rst_i = 1'b1;
    we_i = 1'b0;
    #1 check_reset_outputs("rst.mid");
    model_errcnt = 0;
    model_rdata  = '0;
    next_cycle();
    rst_i = 1'b0;
    slv_rvalid_i = 4'b1000;
    slv_rdata_i[127:96] = 32'hCAFEF00D;
    @(negedge clk_i);
    check_reset_outputs("rst.late");
    next_cycle();
    slv_rvalid_i = '0;
    @(negedge clk_i);
    check_reset_outputs("rst.after");
    run_txn(32'h00000020, 1'b0, 2, 32'hA5A5A5A5, 1'b0);

    // Drive enough unmapped accesses to hit counter saturation.
    for (int t = 0; t < 270; t++) begin
      run_txn(32'h80002000 + 32'(t * 4), 1'b0, 1, 32'h0, 1'b0);
    end
    idle_cycle();
    check_eq("sat.err_cnt", err_cnt_o, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_decoder_fsm.md
Name: bus_decoder_fsm

Overview:
Parametrised N-channel memory-mapped decoder between the core's data port and its peripherals (RAM, LEDs, HEX, PS/2, ...). Each channel is a base/mask address window.
- Routes a single outstanding request to the matching slave, then waits for that slave's response.
- Returns registered read data to the core.
- Generates a bus error for unmapped addresses and, optionally, for slave timeouts.

Parameters:
N_SLAVES, 4, number of slave channels (1..8)
SLV_BASE, {32'h80003000, 32'h80001000, 32'h80000800, 32'h00000000}, packed N_SLAVES*32 base addresses; channel k is bits [32k+31:32k]
SLV_MASK, {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFFF00}, packed N_SLAVES*32 compare masks, same packing
TIMEOUT, 16, cycles allowed in WAIT before error (only with timeout feature; >=2)
ERRCNT_W, 8, width of error counter

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
req_i  input  1  core request
we_i  input  1  core write enable
addr_i  input  32  core address
gnt_o  output  1  decoder can accept a request this cycle
rvalid_o  output  1  one-cycle response strobe to core
rdata_o  output  32  response read data
err_o  output  1  response is an error (valid with rvalid_o)
busy_o  output  1  transaction in flight
err_cnt_o  output  ERRCNT_W  saturating count of error responses
slv_req_o  output  N_SLAVES  one-hot slave request
slv_we_o  output  1  write enable to slaves, gated by any slv_req_o
slv_addr_o  output  32  addr_i passed through
slv_rvalid_i  input  N_SLAVES  per-slave response strobe
slv_rdata_i  input  N_SLAVES*32  per-slave read data, same packing as SLV_BASE

Behaviour:
- Clock and reset are fixed: one clock, clk_i; asynchronous active-high reset, rst_i.
- Decode: hit[k] = ((addr_i & MASK[k]) == BASE[k]). On overlapping windows the lowest index wins; miss = no hit.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - gnt_o=1.
  - If req_i && hit: slv_req_o[k]=1 combinationally in the same cycle, and slv_we_o=we_i. Latch k into sel_q, clear timeout counter, next state WAIT.
  - If req_i && miss: no slv_req_o. Latch err_q=1, rdata_q=0, next state RESP.
- WAIT:
  - gnt_o=0, slv_req_o=0.
  - slv_rvalid_i is sampled only for sel_q; strobes from other channels are ignored.
  - On slv_rvalid_i[sel_q]: capture rdata_q=slv_rdata_i[sel_q], err_q=0, next state RESP. The data is captured for both reads and writes; writes also require an rvalid acknowledgement.
  - A slave rvalid asserted in the same cycle as the request (IDLE) is ignored; the earliest legal slave response is one cycle after the request.
- RESP:
  - gnt_o=0, rvalid_o=1, rdata_o=rdata_q, err_o=err_q. RESP lasts exactly one cycle, then IDLE.
  - rvalid_o, rdata_o and err_o come from registers. rdata_o holds its last value outside RESP, and err_o is 0 outside RESP.
- Latency: unmapped access gives rvalid_o one cycle after acceptance. Mapped access gives rvalid_o one cycle after slv_rvalid_i. Minimum request-to-response latency for mapped accesses is 2 cycles.
- busy_o=1 in WAIT and RESP.
- err_cnt_o increments by 1 on each cycle with rvalid_o && err_o, and saturates at all-ones without wrapping.
- Reset (including mid-transaction): state=IDLE; sel_q, rdata_q, err_q and counters are 0.
  - Reset values: gnt_o=1, rvalid_o=0, err_o=0, rdata_o=0, busy_o=0, err_cnt_o=0, slv_req_o=0, slv_we_o=0.
  - A slave response arriving after reset is ignored.

Optional Feature:
Macro BUS_DECODER_TIMEOUT_EN.
- Defined: in WAIT, a counter increments each cycle. If it reaches TIMEOUT-1 without slv_rvalid_i[sel_q], the FSM goes to RESP with err_q=1 and rdata_q=32'hDEADBEEF; that response is counted in err_cnt_o. A slave response arriving in the same cycle the timeout triggers takes priority and returns normal data. A slave response arriving after the timeout is ignored.
- Undefined: no counter logic; WAIT persists until the selected slave responds.

Test Plan:
- Read 0x00000010 with RAM (ch0) rvalid 1 cycle later and data 0x12345678 -> slv_req_o=4'b0001 in the request cycle; rvalid_o=1 with rdata_o=0x12345678, err_o=0 one cycle after slave rvalid.
- Write 0x80000802 (ch1, LEDs) -> slv_req_o=4'b0010, slv_we_o=1; gnt_o=0 until the response; rvalid_o with err_o=0.
- Read 0x80002000 (unmapped) -> slv_req_o stays 0; next cycle rvalid_o=1, err_o=1, rdata_o=0; err_cnt_o goes from 0 to 1.
- Read 0x80001004 (ch2) while ch3 pulses rvalid with 0xAAAA5555, then ch2 returns 0x0000000F -> rdata_o=0x0000000F; the ch3 pulse is ignored.
- With BUS_DECODER_TIMEOUT_EN and TIMEOUT=16, read ch3 and the slave never responds -> rvalid_o=1, err_o=1, rdata_o=0xDEADBEEF 16 cycles after the request; gnt_o=1 on the following cycle.
- Assert rst_i during WAIT, then deassert and have the old slave respond -> all outputs at reset values; no rvalid_o; a new request to ch0 completes normally.
